// File: rtl/obd_hex_line_rx_if.sv
// Decoded byte stream from the ELM327 hex line receiver to the OBD PID decoder.
// The master drives data/valid/eol/err, and the slave drives ready.
interface obd_hex_line_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_eol;
  logic       out_err;

  modport master (
    output out_data,
    output out_valid,
    output out_eol,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_eol,
    input  out_err,
    output out_ready
  );
endinterface

// File: rtl/obd_hex_line_rx.sv
// Pops ASCII characters from the UART RX FIFO, parses ELM327 hex response lines and
// emits decoded bytes plus one end-of-line beat per line on a valid/ready stream.
module obd_hex_line_rx #(
  parameter int RD_LAT    = 3,
  parameter int MAX_BYTES = 16,
  parameter int CNT_BITS  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_empty,
  input  logic [7:0]          r_data,
  output logic                rd_uart,
  obd_hex_line_rx_if.master   out_if,
  output logic [CNT_BITS-1:0] byte_cnt,
  output logic                prompt_tick,
  output logic                e_char,
  output logic                e_len,
  input  logic                clr_err
);

  localparam int WC_BITS = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_GT = 8'h3E;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_PARSE = 3'd3,
    S_EMIT  = 3'd4,
    S_EOL   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [WC_BITS-1:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]          hi_q, hi_d;
  logic                pend_q, pend_d;
  logic                line_bad_q, line_bad_d;
  logic [CNT_BITS-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]          data_q, data_d;
  logic                err_q, err_d;
  logic                rd_q, rd_d;
  logic                valid_q, valid_d;
  logic                eol_q, eol_d;
  logic                prompt_q, prompt_d;
  logic                e_char_q, e_char_d;
  logic                e_len_q, e_len_d;
  logic                set_char_s, set_len_s;
  logic                line_open_s;
  logic [4:0]          nib_s;

  // Returns {is_hex, nibble} for an ASCII character; is_hex=0 for any non-hex char.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      r = {1'b1, c[3:0]};
    end else if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66))) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

  assign nib_s       = hex_decode(r_data);
  assign line_open_s = (byte_cnt_q != {CNT_BITS{1'b0}}) || pend_q || line_bad_q;

  // Next-state, line bookkeeping and output register inputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hi_d       = hi_q;
    pend_d     = pend_q;
    line_bad_d = line_bad_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    prompt_d   = 1'b0;
    set_char_s = 1'b0;
    set_len_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        wait_cnt_d = {WC_BITS{1'b0}};
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WC_BITS'(RD_LAT - 1)) begin
          wait_cnt_d = {WC_BITS{1'b0}};
          state_d    = S_PARSE;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_BITS'(1);
        end
      end
      S_PARSE: begin
        state_d = S_IDLE;
        if (nib_s[4]) begin
          // A poisoned line swallows hex until its terminator.
          if (line_bad_q) begin
            pend_d = 1'b0;
          end else if (!pend_q) begin
            hi_d   = nib_s[3:0];
            pend_d = 1'b1;
          end else begin
            pend_d = 1'b0;
            if (byte_cnt_q >= CNT_BITS'(MAX_BYTES)) begin
              set_len_s  = 1'b1;
              line_bad_d = 1'b1;
            end else begin
              data_d  = {hi_q, nib_s[3:0]};
              state_d = S_EMIT;
            end
          end
        end else begin
          case (r_data)
            CH_SP, CH_LF: begin
              if (pend_q) begin
                set_char_s = 1'b1;
                line_bad_d = 1'b1;
                pend_d     = 1'b0;
              end else begin
                pend_d = 1'b0;
              end
            end
            CH_CR, CH_GT: begin
              prompt_d = (r_data == CH_GT);
              if (pend_q) begin
                line_bad_d = 1'b1;
              end else begin
                line_bad_d = line_bad_q;
              end
              pend_d = 1'b0;
              if (line_open_s) begin
                data_d  = 8'h00;
                state_d = S_EOL;
              end else begin
                state_d = S_IDLE;
              end
            end
            default: begin
              set_char_s = 1'b1;
              line_bad_d = 1'b1;
              pend_d     = 1'b0;
            end
          endcase
        end
      end
      S_EMIT: begin
        if (out_if.out_ready) begin
          byte_cnt_d = byte_cnt_q + CNT_BITS'(1);
          state_d    = S_IDLE;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EOL: begin
        if (out_if.out_ready) begin
          byte_cnt_d = {CNT_BITS{1'b0}};
          line_bad_d = 1'b0;
          pend_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_EOL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_d     = (state_d == S_POP);
    valid_d  = (state_d == S_EMIT) || (state_d == S_EOL);
    eol_d    = (state_d == S_EOL);
    err_d    = (state_d == S_EOL) ? line_bad_d : 1'b0;
    // A new error event in the same cycle as clr_err keeps the flag set.
    e_char_d = set_char_s ? 1'b1 : (clr_err ? 1'b0 : e_char_q);
    e_len_d  = set_len_s  ? 1'b1 : (clr_err ? 1'b0 : e_len_q);
  end

  // State and output registers; async reset discards any partial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= {WC_BITS{1'b0}};
      hi_q       <= 4'h0;
      pend_q     <= 1'b0;
      line_bad_q <= 1'b0;
      byte_cnt_q <= {CNT_BITS{1'b0}};
      data_q     <= 8'h00;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      valid_q    <= 1'b0;
      eol_q      <= 1'b0;
      prompt_q   <= 1'b0;
      e_char_q   <= 1'b0;
      e_len_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hi_q       <= hi_d;
      pend_q     <= pend_d;
      line_bad_q <= line_bad_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
      eol_q      <= eol_d;
      prompt_q   <= prompt_d;
      e_char_q   <= e_char_d;
      e_len_q    <= e_len_d;
    end
  end

  assign rd_uart          = rd_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_eol   = eol_q;
  assign out_if.out_err   = err_q;
  assign byte_cnt         = byte_cnt_q;
  assign prompt_tick      = prompt_q;
  assign e_char           = e_char_q;
  assign e_len            = e_len_q;

endmodule
